// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Owner encoding doubles as the round-robin last-grant value.
package mips_mem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;
  localparam int   MAX_WAIT  = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU, debug and memory-side signals of the arbiter; slave = arbiter, master = surrounding system.
// Requesters hold req/we/adr/wd until their ready pulse.
interface mem_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wd;
  logic [DW-1:0] cpu_rd;
  logic          cpu_ready;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_adr;
  logic [DW-1:0] dbg_wd;
  logic [DW-1:0] dbg_rd;
  logic          dbg_ready;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  logic          owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wd,
    output cpu_rd, cpu_ready,
    input  dbg_req, dbg_we, dbg_adr, dbg_wd,
    output dbg_rd, dbg_ready,
    output mem_en, mem_we, mem_adr, mem_wd,
    input  mem_rd,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wd,
    input  cpu_rd, cpu_ready,
    output dbg_req, dbg_we, dbg_adr, dbg_wd,
    input  dbg_rd, dbg_ready,
    input  mem_en, mem_we, mem_adr, mem_wd,
    output mem_rd,
    input  owner
  );

endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Two-requester round-robin grant; a tie goes to the requester that did not win last time.
// last_grant only moves on an enabled edge with at least one request present.
module rr_arbiter2
  import mips_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       gnt_en,
  output logic       gnt,
  output logic       last_grant
);

  always_comb begin
    gnt = last_grant;
    case (req)
      2'b01:   gnt = OWNER_CPU;
      2'b10:   gnt = OWNER_DBG;
      2'b11:   gnt = ~last_grant;
      default: gnt = last_grant;
    endcase
  end

  // Reset to debug so the CPU takes the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_grant <= OWNER_DBG;
    else if (gnt_en && (|req))
      last_grant <= gnt;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between CPU and debug ports: IDLE -> ACCESS (WAIT cycles) -> RESP (1-cycle ready).
// Latency WAIT+1 from accept to ready, one access per WAIT+2 cycles; losing requester waits for the next grant.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int WAIT = 2
) (
  input logic              clk,
  input logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int            CW   = $clog2(WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT - 1);

  if ((WAIT < 1) || (WAIT > MAX_WAIT)) begin : g_bad_wait
    $error("mem_port_arbiter: WAIT must be in 1..15");
  end

  arb_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [AW-1:0] lat_adr;
  logic [DW-1:0] lat_wd;
  logic [DW-1:0] rd_q, cpu_rd_q, dbg_rd_q;
  logic          gnt, owner_q, accept, last_cyc;
  logic          en_c, we_c, cpu_rdy_c, dbg_rdy_c;

  assign accept   = (state == IDLE) && (bus.cpu_req || bus.dbg_req);
  assign last_cyc = (state == ACCESS) && (cnt == LAST);

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        ({bus.dbg_req, bus.cpu_req}),
    .gnt_en     (state == IDLE),
    .gnt        (gnt),
    .last_grant (owner_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    en_c      = 1'b0;
    we_c      = 1'b0;
    cpu_rdy_c = 1'b0;
    dbg_rdy_c = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ACCESS;
      end
      ACCESS: begin
        en_c = 1'b1;
        we_c = lat_we && (cnt == LAST);
        if (cnt == LAST) state_nxt = RESP;
      end
      RESP: begin
        cpu_rdy_c = (owner_q == OWNER_CPU);
        dbg_rdy_c = (owner_q == OWNER_DBG);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request is frozen at the grant edge; requester-side changes during ACCESS are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      lat_we   <= 1'b0;
      lat_adr  <= '0;
      lat_wd   <= '0;
      rd_q     <= '0;
      cpu_rd_q <= '0;
      dbg_rd_q <= '0;
    end else begin
      if (accept) begin
        lat_we  <= gnt ? bus.dbg_we  : bus.cpu_we;
        lat_adr <= gnt ? bus.dbg_adr : bus.cpu_adr;
        lat_wd  <= gnt ? bus.dbg_wd  : bus.cpu_wd;
      end
      if (state == ACCESS)
        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      if (last_cyc)
        rd_q <= bus.mem_rd;
      if (state == RESP) begin
        if (owner_q == OWNER_CPU) cpu_rd_q <= rd_q;
        else                      dbg_rd_q <= rd_q;
      end
    end
  end

  assign bus.mem_en    = en_c;
  assign bus.mem_we    = we_c;
  assign bus.mem_adr   = lat_adr;
  assign bus.mem_wd    = lat_wd;
  assign bus.cpu_ready = cpu_rdy_c;
  assign bus.dbg_ready = dbg_rdy_c;
  assign bus.cpu_rd    = cpu_rdy_c ? rd_q : cpu_rd_q;
  assign bus.dbg_rd    = dbg_rdy_c ? rd_q : dbg_rd_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: WAIT=2 instance (a) for arbitration/datapath scenarios, WAIT=1 instance (b) for back-to-back reads.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   n_pass = 0;
  int   n_total = 0;
  int   wr_cnt_a = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DW(32), .AW(32)) ifa ();
  mem_port_arbiter_if #(.DW(32), .AW(32)) ifb ();

  mem_port_arbiter #(.DW(32), .AW(32), .WAIT(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  mem_port_arbiter #(.DW(32), .AW(32), .WAIT(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  // Word memories: unwritten words read a fixed preload pattern.
  function automatic logic [31:0] init_val(input logic [7:0] idx);
    case (idx)
      8'h00:   return 32'h2002_0005;
      8'h14:   return 32'hA5A5_0050;
      8'h18:   return 32'hFFFF_0000;
      8'h20:   return 32'hDEAD_0080;
      default: return {24'hC0DE00, idx};
    endcase
  endfunction

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  bit   [255:0] wr_a, wr_b;
  logic [7:0]  ia, ib;

  assign ia = ifa.mem_adr[9:2];
  assign ib = ifb.mem_adr[9:2];

  always_comb ifa.mem_rd = wr_a[ia] ? mem_a[ia] : init_val(ia);
  always_comb ifb.mem_rd = wr_b[ib] ? mem_b[ib] : init_val(ib);

  always @(posedge clk) begin
    if (ifa.mem_we) begin
      mem_a[ia] <= ifa.mem_wd;
      wr_a[ia]  <= 1'b1;
      wr_cnt_a  <= wr_cnt_a + 1;
    end
    if (ifb.mem_we) begin
      mem_b[ib] <= ifb.mem_wd;
      wr_b[ib]  <= 1'b1;
    end
  end

  task automatic test_reset();
    n_total++; if (ifa.cpu_ready !== 1'b0) $display("FAIL reset_cpu_ready got %b want 0", ifa.cpu_ready); else n_pass++;
    n_total++; if (ifa.dbg_ready !== 1'b0) $display("FAIL reset_dbg_ready got %b want 0", ifa.dbg_ready); else n_pass++;
    n_total++; if (ifa.mem_en !== 1'b0) $display("FAIL reset_mem_en got %b want 0", ifa.mem_en); else n_pass++;
    n_total++; if (ifa.mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", ifa.mem_we); else n_pass++;
    n_total++; if (ifa.mem_adr !== 32'h0) $display("FAIL reset_mem_adr got %h want 0", ifa.mem_adr); else n_pass++;
    n_total++; if (ifa.mem_wd !== 32'h0) $display("FAIL reset_mem_wd got %h want 0", ifa.mem_wd); else n_pass++;
    n_total++; if (ifa.cpu_rd !== 32'h0) $display("FAIL reset_cpu_rd got %h want 0", ifa.cpu_rd); else n_pass++;
    n_total++; if (ifa.dbg_rd !== 32'h0) $display("FAIL reset_dbg_rd got %h want 0", ifa.dbg_rd); else n_pass++;
    n_total++; if (ifa.owner !== 1'b1) $display("FAIL reset_owner got %b want 1", ifa.owner); else n_pass++;
    n_total++; if (ifb.owner !== 1'b1) $display("FAIL reset_owner_b got %b want 1", ifb.owner); else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_total++; if (ifa.mem_en !== 1'b0) $display("FAIL idle_after_reset mem_en got %b want 0", ifa.mem_en); else n_pass++;
  endtask

  task automatic test_cpu_read();
    int en_cnt = 0, rdy_k = 0, rdy_cnt = 0;
    logic dbg_seen = 1'b0;
    logic [31:0] rd_val = '0;
    ifa.cpu_we = 1'b0; ifa.cpu_adr = 32'h00; ifa.cpu_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (ifa.mem_en) en_cnt++;
      if (ifa.dbg_ready) dbg_seen = 1'b1;
      if (ifa.cpu_ready) begin
        rdy_cnt++;
        if (rdy_k == 0) begin rdy_k = k; rd_val = ifa.cpu_rd; end
        ifa.cpu_req = 1'b0;
      end
    end
    n_total++; if (en_cnt != 2) $display("FAIL cpu_read_en_cycles got %0d want 2", en_cnt); else n_pass++;
    n_total++; if (rdy_k != 3) $display("FAIL cpu_read_latency got %0d want 3", rdy_k); else n_pass++;
    n_total++; if (rdy_cnt != 1) $display("FAIL cpu_read_ready_width got %0d want 1", rdy_cnt); else n_pass++;
    n_total++; if (rd_val !== 32'h2002_0005) $display("FAIL cpu_read_data got %h want 20020005", rd_val); else n_pass++;
    n_total++; if (dbg_seen !== 1'b0) $display("FAIL cpu_read_dbg_ready got %b want 0", dbg_seen); else n_pass++;
    n_total++; if (ifa.owner !== 1'b0) $display("FAIL cpu_read_owner got %b want 0", ifa.owner); else n_pass++;
    n_total++; if (ifa.cpu_rd !== 32'h2002_0005) $display("FAIL cpu_rd_hold got %h want 20020005", ifa.cpu_rd); else n_pass++;
  endtask

  task automatic test_dbg_write();
    int we_cnt = 0, we_k = 0, rdy_k = 0;
    logic [31:0] we_adr = '0, we_wd = '0, rd_val = '0;
    ifa.dbg_we = 1'b1; ifa.dbg_adr = 32'h54; ifa.dbg_wd = 32'h7; ifa.dbg_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (ifa.mem_we) begin
        we_cnt++;
        if (we_k == 0) begin we_k = k; we_adr = ifa.mem_adr; we_wd = ifa.mem_wd; end
      end
      if (ifa.dbg_ready && rdy_k == 0) begin rdy_k = k; ifa.dbg_req = 1'b0; end
    end
    ifa.dbg_we = 1'b0;
    n_total++; if (we_cnt != 1) $display("FAIL dbg_write_we_cycles got %0d want 1", we_cnt); else n_pass++;
    n_total++; if (we_k != 2) $display("FAIL dbg_write_we_cycle got %0d want 2", we_k); else n_pass++;
    n_total++; if (we_adr !== 32'h54) $display("FAIL dbg_write_adr got %h want 54", we_adr); else n_pass++;
    n_total++; if (we_wd !== 32'h7) $display("FAIL dbg_write_wd got %h want 7", we_wd); else n_pass++;
    n_total++; if (rdy_k != 3) $display("FAIL dbg_write_ready got %0d want 3", rdy_k); else n_pass++;
    n_total++; if (ifa.owner !== 1'b1) $display("FAIL dbg_write_owner got %b want 1", ifa.owner); else n_pass++;
    n_total++; if (ifa.cpu_rd !== 32'h2002_0005) $display("FAIL cpu_rd_hold_dbg got %h want 20020005", ifa.cpu_rd); else n_pass++;
    rdy_k = 0;
    ifa.cpu_we = 1'b0; ifa.cpu_adr = 32'h54; ifa.cpu_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (ifa.cpu_ready && rdy_k == 0) begin rdy_k = k; rd_val = ifa.cpu_rd; ifa.cpu_req = 1'b0; end
    end
    n_total++; if (rdy_k != 3) $display("FAIL readback_latency got %0d want 3", rdy_k); else n_pass++;
    n_total++; if (rd_val !== 32'h7) $display("FAIL readback_data got %h want 7", rd_val); else n_pass++;
  endtask

  task automatic test_alternate();
    int n_rdy = 0, both = 0;
    int rk [4];
    logic who [4];
    logic own [4];
    logic [31:0] dat [4];
    reset_n = 1'b0;
    ifa.cpu_we = 1'b0; ifa.cpu_adr = 32'h00; ifa.cpu_req = 1'b1;
    ifa.dbg_we = 1'b0; ifa.dbg_adr = 32'h54; ifa.dbg_req = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (ifa.cpu_ready && ifa.dbg_ready) both++;
      if ((ifa.cpu_ready || ifa.dbg_ready) && n_rdy < 4) begin
        rk[n_rdy]  = k;
        who[n_rdy] = ifa.dbg_ready;
        own[n_rdy] = ifa.owner;
        dat[n_rdy] = ifa.dbg_ready ? ifa.dbg_rd : ifa.cpu_rd;
        n_rdy++;
        if (n_rdy == 4) begin ifa.cpu_req = 1'b0; ifa.dbg_req = 1'b0; end
      end
    end
    n_total++; if (n_rdy != 4) $display("FAIL rr_ready_count got %0d want 4", n_rdy); else n_pass++;
    n_total++; if (both != 0) $display("FAIL rr_both_ready got %0d want 0", both); else n_pass++;
    for (int i = 0; i < n_rdy; i++) begin
      n_total++; if (who[i] !== 1'(i % 2)) $display("FAIL rr_grant[%0d] got %b want %b", i, who[i], 1'(i % 2)); else n_pass++;
      n_total++; if (rk[i] != 3 + 4 * i) $display("FAIL rr_ready_time[%0d] got %0d want %0d", i, rk[i], 3 + 4 * i); else n_pass++;
      n_total++; if (own[i] !== 1'(i % 2)) $display("FAIL rr_owner[%0d] got %b want %b", i, own[i], 1'(i % 2)); else n_pass++;
      n_total++; if (dat[i] !== ((i % 2) ? 32'h7 : 32'h2002_0005))
        $display("FAIL rr_data[%0d] got %h want %h", i, dat[i], ((i % 2) ? 32'h7 : 32'h2002_0005)); else n_pass++;
    end
  endtask

  task automatic test_adr_change();
    int rdy_k = 0;
    logic [31:0] adr_k2 = '0, rd_val = '0;
    ifa.cpu_we = 1'b0; ifa.cpu_adr = 32'h50; ifa.cpu_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) ifa.cpu_adr = 32'h80;
      if (k == 2) adr_k2 = ifa.mem_adr;
      if (ifa.cpu_ready && rdy_k == 0) begin rdy_k = k; rd_val = ifa.cpu_rd; ifa.cpu_req = 1'b0; end
    end
    n_total++; if (adr_k2 !== 32'h50) $display("FAIL adr_change_mem_adr got %h want 50", adr_k2); else n_pass++;
    n_total++; if (rdy_k != 3) $display("FAIL adr_change_latency got %0d want 3", rdy_k); else n_pass++;
    n_total++; if (rd_val !== 32'hA5A5_0050) $display("FAIL adr_change_data got %h want a5a50050", rd_val); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int wr_before, rdy_k = 0;
    logic [31:0] rd_val = '0;
    wr_before = wr_cnt_a;
    ifa.cpu_we = 1'b1; ifa.cpu_adr = 32'h60; ifa.cpu_wd = 32'h1234; ifa.cpu_req = 1'b1;
    @(negedge clk);
    n_total++; if (ifa.mem_en !== 1'b1) $display("FAIL rst_mid_precond mem_en got %b want 1", ifa.mem_en); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++; if (ifa.mem_en !== 1'b0) $display("FAIL rst_mid_mem_en got %b want 0", ifa.mem_en); else n_pass++;
    n_total++; if (ifa.mem_we !== 1'b0) $display("FAIL rst_mid_mem_we got %b want 0", ifa.mem_we); else n_pass++;
    n_total++; if (ifa.cpu_ready !== 1'b0) $display("FAIL rst_mid_cpu_ready got %b want 0", ifa.cpu_ready); else n_pass++;
    ifa.cpu_req = 1'b0; ifa.cpu_we = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_total++; if (ifa.mem_en !== 1'b0) $display("FAIL rst_mid_idle mem_en got %b want 0", ifa.mem_en); else n_pass++;
    n_total++; if (wr_cnt_a != wr_before) $display("FAIL rst_mid_writes got %0d want %0d", wr_cnt_a, wr_before); else n_pass++;
    ifa.cpu_adr = 32'h60; ifa.cpu_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (ifa.cpu_ready && rdy_k == 0) begin rdy_k = k; rd_val = ifa.cpu_rd; ifa.cpu_req = 1'b0; end
    end
    n_total++; if (rdy_k != 3) $display("FAIL rst_mid_after_latency got %0d want 3", rdy_k); else n_pass++;
    n_total++; if (rd_val !== 32'hFFFF_0000) $display("FAIL rst_mid_mem_intact got %h want ffff0000", rd_val); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n_en = 0, n_rdy = 0;
    int en_k [2];
    int rdy_k [2];
    logic [31:0] dat [2];
    logic en_prev = 1'b0;
    en_k = '{0, 0}; rdy_k = '{0, 0}; dat = '{32'h0, 32'h0};
    ifb.cpu_we = 1'b0; ifb.cpu_adr = 32'h04; ifb.cpu_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ifb.mem_en && !en_prev && n_en < 2) begin en_k[n_en] = k; n_en++; end
      en_prev = ifb.mem_en;
      if (ifb.cpu_ready && n_rdy < 2) begin
        rdy_k[n_rdy] = k; dat[n_rdy] = ifb.cpu_rd; n_rdy++;
        if (n_rdy == 1) ifb.cpu_adr = 32'h08;
        else            ifb.cpu_req = 1'b0;
      end
    end
    n_total++; if (en_k[0] != 1) $display("FAIL b2b_accept0 got %0d want 1", en_k[0]); else n_pass++;
    n_total++; if (en_k[1] != 4) $display("FAIL b2b_accept1 got %0d want 4", en_k[1]); else n_pass++;
    n_total++; if (rdy_k[0] != 2) $display("FAIL b2b_ready0 got %0d want 2", rdy_k[0]); else n_pass++;
    n_total++; if (rdy_k[1] != 5) $display("FAIL b2b_ready1 got %0d want 5", rdy_k[1]); else n_pass++;
    n_total++; if (dat[0] !== 32'hC0DE_0001) $display("FAIL b2b_data0 got %h want c0de0001", dat[0]); else n_pass++;
    n_total++; if (dat[1] !== 32'hC0DE_0002) $display("FAIL b2b_data1 got %h want c0de0002", dat[1]); else n_pass++;
  endtask

  initial begin
    reset_n = 1'b0;
    ifa.cpu_req = 1'b0; ifa.cpu_we = 1'b0; ifa.cpu_adr = '0; ifa.cpu_wd = '0;
    ifa.dbg_req = 1'b0; ifa.dbg_we = 1'b0; ifa.dbg_adr = '0; ifa.dbg_wd = '0;
    ifb.cpu_req = 1'b0; ifb.cpu_we = 1'b0; ifb.cpu_adr = '0; ifb.cpu_wd = '0;
    ifb.dbg_req = 1'b0; ifb.dbg_we = 1'b0; ifb.dbg_adr = '0; ifb.dbg_wd = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_alternate();
    test_adr_change();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the unified instruction/data memory of the multicycle MIPS CPU between two requesters: the CPU memory port and a debug/loader port that preloads programs and inspects memory.
- Sits between the CPU datapath (IorD-selected address, writedata, memwrite) and the shared memory array. Inserts configurable wait states.
- Returns a one-cycle ready pulse per access, which the CPU controller uses as a stall/advance condition.

Parameters:
- DW, 32, data width
- AW, 32, address width
- WAIT, 2, memory access cycles per transfer; legal range 1..15

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ready
- cpu_we  in  1  CPU write enable (qualifies cpu_req)
- cpu_adr  in  AW  CPU byte address
- cpu_wd  in  DW  CPU write data
- cpu_rd  out  DW  CPU read data, valid when cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse to CPU
- dbg_req  in  1  debug request; held until dbg_ready
- dbg_we  in  1  debug write enable
- dbg_adr  in  AW  debug byte address
- dbg_wd  in  DW  debug write data
- dbg_rd  out  DW  debug read data, valid when dbg_ready=1
- dbg_ready  out  1  one-cycle completion pulse to debug
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_adr  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory read data, combinational from mem_adr
- owner  out  1  current/last grant: 0=CPU, 1=debug

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: state IDLE, counter 0, owner/last_grant=1 (so the CPU wins the first tie), all ready/mem_en/mem_we=0, mem_adr/mem_wd=0, cpu_rd/dbg_rd/rd_q=0.
- FSM states:
  - IDLE: sample requests; nothing asserted to memory.
  - ACCESS: mem_en=1 for exactly WAIT cycles.
  - RESP: exactly 1 cycle; ready pulse to the granted requester.
- IDLE -> ACCESS when any req=1 at a clock edge. At that edge the winner's we/adr/wd are latched into internal registers, and mem_adr/mem_wd drive from those registers for all of ACCESS.
- Arbitration is round-robin:
  - single requester: that requester wins.
  - both requesting: winner is the one not equal to last_grant.
  - owner updates at the grant edge.
- ACCESS counter runs 0..WAIT-1. On the edge where counter==WAIT-1: go to RESP, capture mem_rd into rd_q, clear the counter.
- mem_we=1 only in the final ACCESS cycle (counter==WAIT-1) and only if latched we=1. Each write is exactly one cycle.
- RESP:
  - granted requester's ready=1; its rd output = rd_q.
  - other ready=0; its rd output holds its previous value.
  - reads and writes both return a ready pulse; rd_q after a write is don't-care but deterministic (memory contents at that address).
  - RESP -> IDLE unconditionally.
- Latency and throughput:
  - latency from the accepting edge to ready: WAIT+1 cycles.
  - throughput: one access per WAIT+2 cycles.
- Requester rules:
  - keep req, we, adr, wd stable until ready.
  - deassert req, or present the next request, in the cycle after ready.
  - changes to req/adr during ACCESS are ignored because the request is already latched.
- A req of the losing requester stays pending; it is guaranteed the next grant (no starvation).
- Reset mid-ACCESS: immediate return to IDLE, and mem_we drops asynchronously. The interrupted write may have occurred only if its strobe cycle was already completed. No ready pulse is issued.
- Counter width: $clog2(WAIT+1) bits. WAIT values outside 1..15 trigger an elaboration-time assertion.

Decomposition:
- Shared package mips_mem_pkg:
  - typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t
  - localparam OWNER_CPU=1'b0, OWNER_DBG=1'b1
  - localparam MAX_WAIT=15
- One natural sub-module: rr_arbiter2, a two-requester round-robin grant with last_grant register and grant-enable input. It is instantiated once.
- FSM, counter and datapath latches stay in mem_port_arbiter.

Test Plan:
- CPU read alone, WAIT=2, mem[0x00]=0x20020005, cpu_adr=0x00 → mem_en high 2 cycles, cpu_ready pulses exactly 3 cycles after the accepting edge, cpu_rd=0x20020005, dbg_ready stays 0.
- Debug write dbg_adr=0x54 dbg_wd=7 → mem_we high exactly 1 cycle with mem_adr=0x54 and mem_wd=7; a following CPU read of 0x54 returns 7.
- Both requesting continuously from reset → grants alternate CPU, DBG, CPU, DBG; each ready spaced WAIT+2=4 cycles apart; owner toggles at each grant.
- cpu_adr changed from 0x50 to 0x80 mid-ACCESS → mem_adr stays 0x50 until RESP; returned data is from 0x50.
- reset_n asserted low during the first ACCESS cycle of a write → mem_we, mem_en and cpu_ready are 0 immediately; no write to memory; state IDLE after release.
- WAIT=1 build, CPU read then immediate second read → ready pulses 2 cycles after each accept; accepts spaced 3 cycles apart.
